// File: rtl/cio_tx_fifo.sv
// Console-output TX FIFO: converts 3-digit BCD cells to character codes, queues them and
// drains them as timed tx_data/tx_vld pulses on the negedge of Clock_1us. Optional: CIO_PRINTABLE_EN.
`timescale 1ns/1ps
module cio_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int TX_HOLD = 4,
  parameter int TX_GAP  = 2000
) (
  input  logic                   Rst_n,
  input  logic                   Clock_1us,
  input  logic [11:0]            cio_data,
  input  logic                   cio_wr,
  output logic                   cio_ready,
  input  logic                   flush,
  output logic [7:0]             tx_data,
  output logic                   tx_vld,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   bcd_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (TX_GAP > TX_HOLD) ? TX_GAP : TX_HOLD;
  localparam int CW   = $clog2(CMAX);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] HOLD_LD  = CW'(TX_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(TX_GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            tx_vld_q;
  logic [7:0]      tx_data_q;
  logic            nonempty_q;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [7:0]      mem_q [DEPTH];

  // BCD to binary conversion at write time
  logic [3:0] dig_h, dig_t, dig_u;
  logic [9:0] bin_val;
  logic       bcd_bad;
  logic [7:0] char_code;

  assign {dig_h, dig_t, dig_u} = cio_data;
  assign bin_val = 10'(dig_h) * 10'd100 + 10'(dig_t) * 10'd10 + 10'(dig_u);
  assign bcd_bad = (dig_h > 4'd9) || (dig_t > 4'd9) || (dig_u > 4'd9) || (bin_val > 10'd255);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    char_code = bin_val[7:0];
`ifdef CIO_PRINTABLE_EN
    if (bcd_bad) begin
      char_code = 8'h3F;
    end else if (((bin_val[7:0] < 8'h20) && (bin_val[7:0] != 8'h0A)) || (bin_val[7:0] > 8'h7E)) begin
      char_code = 8'h3F;
    end
`else
    if (bcd_bad) begin
      char_code = 8'hFF;
    end
`endif
  end

  // The FSM sees a one-edge-late copy of "queue non-empty", so a fresh write pops on the 2nd edge.
  logic pop, wr_acc;
  assign pop       = (state_q == ST_IDLE) && nonempty_q && (level_q != '0) && !flush;
  assign cio_ready = (level_q < FULL_LVL) || pop;
  assign wr_acc    = cio_wr && !flush && cio_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !pop)      level_d = level_q + LW'(1);
      else if (pop && !wr_acc) level_d = level_q - LW'(1);
      if (cio_wr && !wr_acc)   ovf_d = 1'b1;
      if (cio_wr && bcd_bad)   err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(negedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      nonempty_q <= (level_q != '0);
    end
  end

  // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
  always_ff @(negedge Clock_1us) begin
    if (wr_acc) mem_q[wr_ptr_q] <= char_code;
  end

  always_ff @(negedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_vld_q  <= 1'b1;
            cnt_q     <= HOLD_LD;
            state_q   <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          // A flush cuts the pulse short but still leaves the consumer a full gap.
          if (flush || (cnt_q == '0)) begin
            tx_vld_q <= 1'b0;
            cnt_q    <= GAP_LD;
            state_q  <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_vld   = tx_vld_q;
  assign tx_busy  = (state_q != ST_IDLE) || (level_q != '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign bcd_err  = err_q;

endmodule
